// File: rtl/wb_tlc_cpld_gen.sv
`default_nettype none
// ============================================================================
// Module      : wb_tlc_cpld_gen
// Description : Packs completion descriptors and a read-data DW stream into
//               64-bit CplD TLP words for the downstream completion FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_tlc_cpld_gen #(
    parameter int c_DATA_WIDTH = 64
) (
    input  logic                    wb_clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_rdy,
    input  logic [9:0]              req_len,
    input  logic [11:0]             req_bytecnt,
    input  logic [6:0]              req_lowaddr,
    input  logic [15:0]             req_id,
    input  logic [7:0]              req_tag,
    input  logic [2:0]              req_tc,
    input  logic [1:0]              req_attr,
    input  logic [15:0]             cpl_id,
    input  logic [31:0]             rd_dw,
    input  logic                    rd_valid,
    output logic                    rd_rdy,
    input  logic                    fifo_afull,
    output logic [c_DATA_WIDTH-1:0] din,
    output logic                    din_sop,
    output logic                    din_eop,
    output logic                    din_dwen,
    output logic                    din_wen
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_HDR0   = 3'd1;
    localparam logic [2:0] c_ST_HDR1   = 3'd2;
    localparam logic [2:0] c_ST_DATA_A = 3'd3;
    localparam logic [2:0] c_ST_DATA_B = 3'd4;

    logic [2:0]  r_state;
    logic [9:0]  r_len;
    logic [11:0] r_bytecnt;
    logic [6:0]  r_lowaddr;
    logic [15:0] r_id;
    logic [7:0]  r_tag;
    logic [2:0]  r_tc;
    logic [1:0]  r_attr;
    logic [10:0] r_rem;
    logic [31:0] r_held;

    logic        w_hs;
    logic        w_last;
    logic [10:0] w_rem_dec;
    logic [31:0] w_dw0;
    logic [31:0] w_dw1;
    logic [31:0] w_dw2;

    assign rd_rdy    = ~rst & ~fifo_afull &
                       ((r_state == c_ST_HDR1) || (r_state == c_ST_DATA_A) ||
                        (r_state == c_ST_DATA_B));
    assign w_hs      = rd_valid & rd_rdy;
    assign w_last    = (r_rem == 11'd1);
    assign w_rem_dec = r_rem - 11'd1;

    assign w_dw0 = {1'b0, 2'b10, 5'b01010, 1'b0, r_tc, 6'b0, r_attr, 2'b0, r_len};
    assign w_dw1 = {cpl_id, 4'b0, r_bytecnt};
    assign w_dw2 = {r_id, r_tag, 1'b0, r_lowaddr};

    always_ff @(posedge wb_clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_len     <= '0;
            r_bytecnt <= '0;
            r_lowaddr <= '0;
            r_id      <= '0;
            r_tag     <= '0;
            r_tc      <= '0;
            r_attr    <= '0;
            r_rem     <= '0;
            r_held    <= '0;
            req_rdy   <= 1'b0;
            din       <= '0;
            din_sop   <= 1'b0;
            din_eop   <= 1'b0;
            din_dwen  <= 1'b0;
            din_wen   <= 1'b0;
        end else begin
            din      <= '0;
            din_sop  <= 1'b0;
            din_eop  <= 1'b0;
            din_dwen <= 1'b0;
            din_wen  <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // req_rdy is raised for one cycle; the descriptor is taken on the following edge
                    if (req_rdy) begin
                        req_rdy <= 1'b0;
                        if (req_valid) begin
                            r_len     <= req_len;
                            r_bytecnt <= req_bytecnt;
                            r_lowaddr <= req_lowaddr;
                            r_id      <= req_id;
                            r_tag     <= req_tag;
                            r_tc      <= req_tc;
                            r_attr    <= req_attr;
                            r_rem     <= {(req_len == 10'd0), req_len};
                            r_state   <= c_ST_HDR0;
                        end
                    end else if (req_valid) begin
                        req_rdy <= 1'b1;
                    end
                end
                c_ST_HDR0: begin
                    if (!fifo_afull) begin
                        din     <= {w_dw0, w_dw1};
                        din_wen <= 1'b1;
                        din_sop <= 1'b1;
                        r_state <= c_ST_HDR1;
                    end
                end
                c_ST_HDR1: begin
                    if (w_hs) begin
                        din     <= {w_dw2, rd_dw};
                        din_wen <= 1'b1;
                        din_eop <= w_last;
                        r_rem   <= w_rem_dec;
                        r_state <= w_last ? c_ST_IDLE : c_ST_DATA_A;
                    end
                end
                c_ST_DATA_A: begin
                    if (w_hs) begin
                        r_rem <= w_rem_dec;
                        // an odd trailing DW closes the TLP as a half-valid word
                        if (w_last) begin
                            din      <= {rd_dw, 32'h0};
                            din_wen  <= 1'b1;
                            din_eop  <= 1'b1;
                            din_dwen <= 1'b1;
                            r_state  <= c_ST_IDLE;
                        end else begin
                            r_held  <= rd_dw;
                            r_state <= c_ST_DATA_B;
                        end
                    end
                end
                c_ST_DATA_B: begin
                    if (w_hs) begin
                        din     <= {r_held, rd_dw};
                        din_wen <= 1'b1;
                        din_eop <= w_last;
                        r_rem   <= w_rem_dec;
                        r_state <= w_last ? c_ST_IDLE : c_ST_DATA_A;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_tlc_cpld_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_tlc_cpld_gen
// Description : Scoreboard bench for wb_tlc_cpld_gen with a TLP-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_tlc_cpld_gen;

    logic        wb_clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_rdy;
    logic [9:0]  req_len;
    logic [11:0] req_bytecnt;
    logic [6:0]  req_lowaddr;
    logic [15:0] req_id;
    logic [7:0]  req_tag;
    logic [2:0]  req_tc;
    logic [1:0]  req_attr;
    logic [15:0] cpl_id;
    logic [31:0] rd_dw;
    logic        rd_valid;
    logic        rd_rdy;
    logic        fifo_afull;
    logic [63:0] din;
    logic        din_sop;
    logic        din_eop;
    logic        din_dwen;
    logic        din_wen;

    always #5 wb_clk = ~wb_clk;

    wb_tlc_cpld_gen #(.c_DATA_WIDTH(64)) dut (
        .wb_clk(wb_clk), .rst(rst),
        .req_valid(req_valid), .req_rdy(req_rdy),
        .req_len(req_len), .req_bytecnt(req_bytecnt), .req_lowaddr(req_lowaddr),
        .req_id(req_id), .req_tag(req_tag), .req_tc(req_tc), .req_attr(req_attr),
        .cpl_id(cpl_id), .rd_dw(rd_dw), .rd_valid(rd_valid), .rd_rdy(rd_rdy),
        .fifo_afull(fifo_afull), .din(din), .din_sop(din_sop), .din_eop(din_eop),
        .din_dwen(din_dwen), .din_wen(din_wen)
    );

    typedef struct packed {
        logic [63:0] d;
        logic        sop;
        logic        eop;
        logic        dwen;
    } word_t;

    word_t       exp_q[$];
    word_t       log_q[$];
    logic [31:0] pay_q[$];

    int   checks    = 0;
    int   failures  = 0;
    int   wr_cnt    = 0;
    int   acc_cnt   = 0;
    int   issued    = 0;
    int   valid_pct = 100;
    int   afull_pct = 0;
    int   af_run    = 0;
    int   force_af  = 0;
    logic af_prev   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every FIFO write and checks per-cycle invariants
    always @(negedge wb_clk) begin : mon
        word_t e;
        if (!rst) begin
            if (din_wen) begin
                wr_cnt++;
                log_q.push_back({din, din_sop, din_eop, din_dwen});
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("din", din, e.d);
                    chk("din_sop", {63'd0, din_sop}, {63'd0, e.sop});
                    chk("din_eop", {63'd0, din_eop}, {63'd0, e.eop});
                    chk("din_dwen", {63'd0, din_dwen}, {63'd0, e.dwen});
                end
                chk("sop_eop_together", {63'd0, din_sop & din_eop}, 64'd0);
            end else begin
                chk("flags_without_wen", {61'd0, din_sop, din_eop, din_dwen}, 64'd0);
            end
            if (af_prev)    chk("wen_after_afull", {63'd0, din_wen}, 64'd0);
            if (fifo_afull) chk("rd_rdy_during_afull", {63'd0, rd_rdy}, 64'd0);
            if (req_rdy)    chk("rd_rdy_in_idle", {63'd0, rd_rdy}, 64'd0);
        end
    end

    always @(posedge wb_clk) begin
        af_prev = fifo_afull;
        if (!rst) begin
            if (rd_valid && rd_rdy && pay_q.size() > 0) void'(pay_q.pop_front());
            if (req_valid && req_rdy) acc_cnt++;
        end
    end

    // Read-data source and FIFO-full generator
    initial begin
        rd_valid   = 1'b0;
        rd_dw      = '0;
        fifo_afull = 1'b0;
        forever begin
            @(negedge wb_clk);
            #1;
            if (pay_q.size() > 0 && $urandom_range(99) < valid_pct) begin
                rd_valid = 1'b1;
                rd_dw    = pay_q[0];
            end else begin
                rd_valid = 1'b0;
                rd_dw    = $urandom;
            end
            if (force_af > 0) begin
                fifo_afull = 1'b1;
                force_af--;
            end else if (af_run > 0) begin
                fifo_afull = 1'b1;
                af_run--;
            end else if ($urandom_range(99) < afull_pct) begin
                fifo_afull = 1'b1;
                af_run     = $urandom_range(4);
            end else begin
                fifo_afull = 1'b0;
            end
        end
    end

    // Reference model: header DWs then payload, zero-padded to an even count, paired into words
    task automatic issue(input logic [9:0] len, input logic [2:0] tc, input logic [1:0] attr,
                         input logic [11:0] bc, input int npay);
        logic [31:0] dws[$];
        logic [15:0] id;
        logic [7:0]  tag;
        logic [6:0]  la;
        logic [31:0] p;
        word_t       w;
        int          n;
        bit          odd;
        bit          got;
        id  = 16'($urandom);
        tag = 8'($urandom);
        la  = 7'($urandom);
        n   = (len == 10'd0) ? 1024 : int'(len);
        dws.push_back(32'h4A00_0000 + (32'(tc) << 20) + (32'(attr) << 12) + 32'(len));
        dws.push_back((32'(cpl_id) << 16) + 32'(bc));
        dws.push_back((32'(id) << 16) + (32'(tag) << 8) + 32'(la));
        for (int i = 0; i < n; i++) begin
            p = $urandom;
            dws.push_back(p);
            if (i < npay) pay_q.push_back(p);
        end
        odd = (dws.size() % 2) == 1;
        if (odd) dws.push_back(32'h0);
        for (int k = 0; k < dws.size(); k += 2) begin
            w.d    = {dws[k], dws[k+1]};
            w.sop  = (k == 0);
            w.eop  = (k + 2 == dws.size());
            w.dwen = w.eop && odd;
            exp_q.push_back(w);
        end
        @(negedge wb_clk);
        req_valid   = 1'b1;
        req_len     = len;
        req_tc      = tc;
        req_attr    = attr;
        req_bytecnt = bc;
        req_id      = id;
        req_tag     = tag;
        req_lowaddr = la;
        got = 0;
        for (int i = 0; i < 6000 && !got; i++) begin
            @(negedge wb_clk);
            if (req_rdy) got = 1;
        end
        if (!got) chk("req_rdy_timeout", 64'd0, 64'd1);
        else      issued++;
        @(negedge wb_clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int i = 0; i < 20000 && !done; i++) begin
            @(negedge wb_clk);
            if (exp_q.size() == 0 && pay_q.size() == 0) done = 1;
        end
        if (!done) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) @(negedge wb_clk);
    endtask

    task automatic wait_writes(input int target);
        bit done;
        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(posedge wb_clk);
            #2;
            if (wr_cnt >= target) done = 1;
        end
        if (!done) chk("write_wait_timeout", 64'(wr_cnt), 64'(target));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int base;
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_len     = '0;
        req_bytecnt = '0;
        req_lowaddr = '0;
        req_id      = '0;
        req_tag     = '0;
        req_tc      = '0;
        req_attr    = '0;
        cpl_id      = 16'($urandom);
        repeat (3) @(negedge wb_clk);
        chk("rst_din_wen", {63'd0, din_wen}, 64'd0);
        chk("rst_req_rdy", {63'd0, req_rdy}, 64'd0);
        chk("rst_rd_rdy", {63'd0, rd_rdy}, 64'd0);
        chk("rst_din", din, 64'd0);
        chk("rst_flags", {61'd0, din_sop, din_eop, din_dwen}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge wb_clk);

        // single-DW completion
        base = wr_cnt;
        issue(10'd1, 3'd0, 2'd0, 12'd4, 1024);
        wait_idle();
        chk("len1_writes", 64'(wr_cnt - base), 64'd2);
        if (log_q.size() > base) chk("len1_dw0", {32'd0, log_q[base].d[63:32]}, 64'h4A00_0001);

        base = wr_cnt;
        issue(10'd2, 3'($urandom), 2'($urandom), 12'($urandom), 1024);
        wait_idle();
        chk("len2_writes", 64'(wr_cnt - base), 64'd3);

        base = wr_cnt;
        issue(10'd0, 3'($urandom), 2'($urandom), 12'($urandom), 1024);
        wait_idle();
        chk("len1024_writes", 64'(wr_cnt - base), 64'd514);

        // back-to-back descriptors with a continuous data stream
        base = acc_cnt;
        issue(10'd3, 3'($urandom), 2'($urandom), 12'($urandom), 1024);
        issue(10'd4, 3'($urandom), 2'($urandom), 12'($urandom), 1024);
        wait_idle();
        chk("b2b_accepts", 64'(acc_cnt - base), 64'd2);

        // five-cycle full stall once the FSM sits in DATA_B
        base = wr_cnt;
        issue(10'd6, 3'($urandom), 2'($urandom), 12'($urandom), 1024);
        wait_writes(base + 2);
        force_af = 5;
        wait_idle();
        chk("stall_writes", 64'(wr_cnt - base), 64'd5);

        // randomized traffic with throttled data and random stalls
        valid_pct = 70;
        afull_pct = 15;
        for (int t = 0; t < 25; t++)
            issue(10'($urandom_range(1, 24)), 3'($urandom), 2'($urandom), 12'($urandom), 1024);
        wait_idle();
        valid_pct = 100;
        afull_pct = 0;
        repeat (8) @(negedge wb_clk);

        // reset while waiting in DATA_A of a len=8 TLP
        base = wr_cnt;
        issue(10'd8, 3'($urandom), 2'($urandom), 12'($urandom), 1);
        wait_writes(base + 2);
        repeat (2) @(negedge wb_clk);
        rst = 1'b1;
        @(negedge wb_clk);
        chk("midrst_din_wen", {63'd0, din_wen}, 64'd0);
        chk("midrst_din", din, 64'd0);
        chk("midrst_flags", {61'd0, din_sop, din_eop, din_dwen}, 64'd0);
        chk("midrst_req_rdy", {63'd0, req_rdy}, 64'd0);
        chk("midrst_rd_rdy", {63'd0, rd_rdy}, 64'd0);
        chk("midrst_writes", 64'(wr_cnt - base), 64'd2);
        exp_q.delete();
        pay_q.delete();
        rst = 1'b0;
        @(negedge wb_clk);

        base = wr_cnt;
        issue(10'd5, 3'($urandom), 2'($urandom), 12'($urandom), 1024);
        wait_idle();
        chk("post_rst_writes", 64'(wr_cnt - base), 64'd4);

        chk("total_accepts", 64'(acc_cnt), 64'(issued));
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_tlc_cpld_gen.md
WB_TLC_CPLD_GEN -- requirements
Module: wb_tlc_cpld_gen

Interface
REQ-001 Parameter c_DATA_WIDTH, default 64, FIFO write word width; only 64 is supported.
REQ-002 Clocking: one clock; reset is synchronous and active-high.
REQ-003 wb_clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  completion request descriptor valid.
REQ-006 req_rdy  out  1  descriptor accepted; 1-cycle pulse.
REQ-007 req_len  in  10  payload length in DW; 0 encodes 1024.
REQ-008 req_bytecnt  in  12  byte count for CplD DW1.
REQ-009 req_lowaddr  in  7  lower address for CplD DW2.
REQ-010 req_id  in  16  requester ID.
REQ-011 req_tag  in  8  request tag.
REQ-012 req_tc  in  3  traffic class.
REQ-013 req_attr  in  2  attributes.
REQ-014 cpl_id  in  16  completer ID, static.
REQ-015 rd_dw  in  32  read-data DW stream from the WB read engine.
REQ-016 rd_valid  in  1  rd_dw valid.
REQ-017 rd_rdy  out  1  rd_dw consumed when rd_valid and rd_rdy are both high.
REQ-018 fifo_afull  in  1  downstream CplD FIFO almost full.
REQ-019 din  out  64  FIFO write word; DW0 in [63:32], DW1 in [31:0].
REQ-020 din_sop  out  1  first word of TLP.
REQ-021 din_eop  out  1  last word of TLP.
REQ-022 din_dwen  out  1  on the eop word only, only [63:32] is valid.
REQ-023 din_wen  out  1  FIFO write strobe.

Function
REQ-024 FSM states and transitions:
- IDLE: on req_valid, latch all req_* fields, pulse req_rdy, go to HDR0.
- HDR0: when ~fifo_afull, write word0, go to HDR1.
- HDR1: on a DW handshake, write word1; go to IDLE if remaining is 0, else to DATA_A.
- DATA_A: on a DW handshake, hold the DW (upper half); if it is the last DW, write it and go to IDLE, else go to DATA_B.
- DATA_B: on a DW handshake, write {held, rd_dw}; go to IDLE if remaining is 0, else to DATA_A.
REQ-025 Word0 = {DW0, DW1}.
- DW0: [31]=0, [30:29]=2'b10, [28:24]=5'b01010, [22:20]=tc, [13:12]=attr, [9:0]=len, all other bits 0.
- DW1: [31:16]=cpl_id, [15:12]=0, [11:0]=bytecnt.
REQ-026 Word1 = {DW2, first payload DW}; DW2 = {req_id, tag, 1'b0, lowaddr}.
REQ-027 Remaining-DW counter:
- 11 bits wide; loaded with len, where 0 loads 1024.
- Decrements once per accepted rd_dw.
REQ-028 rd_rdy = ~fifo_afull in HDR1, DATA_A and DATA_B; 0 in IDLE and HDR0.
REQ-029 fifo_afull stalls: the FSM holds state and held data; no word is lost or duplicated.
REQ-030 Outputs are registered: din/din_wen assert the cycle after the handshake that completes the word.
- din_wen is 0 on any cycle without a completed word.
- din_sop/din_eop/din_dwen are valid only when din_wen=1, else 0.
REQ-031 Last-word rules: din_eop is set on the final word; din_dwen=1 and din[31:0]=0 exactly when (3+len_DW) is odd.
REQ-032 Single-word TLPs are impossible: din_sop and din_eop never assert together.
REQ-033 Back-to-back requests:
- The next descriptor is accepted in the cycle after IDLE is re-entered (IDLE lasts at least one cycle).
- req_rdy is never asserted outside IDLE.
REQ-034 rd_dw arriving while the FSM is in IDLE or HDR0 is not consumed (rd_rdy=0).

Reset
REQ-035 On rst:
- State goes to IDLE and the counter to 0.
- req_rdy, rd_rdy, din_wen, din_sop, din_eop, din_dwen and din all go to 0.
REQ-036 Reset mid-packet abandons the TLP without writing eop; the downstream FIFO shares rst and is flushed.

Verification
REQ-037 len=1, tc=0, attr=0, bytecnt=4, no stall:
- Exactly 2 writes; word1 carries eop=1 and dwen=0.
- Word0[63:32]=32'h4A000001.
REQ-038 len=2: 3 writes; the last write has eop=1, dwen=1, din[31:0]=0 and holds payload DW1 in [63:32].
REQ-039 len=0 (1024 DW): 514 writes, sop on the 1st write only, eop and dwen=1 on the 514th.
REQ-040 Stall: fifo_afull held high for 5 cycles inside DATA_B → rd_rdy=0 and no din_wen during the stall; the payload sequence is intact afterwards.
REQ-041 Two back-to-back descriptors (len=3, len=4) with rd_valid always high:
- The two TLPs are contiguous with correct tags.
- req_rdy pulses twice; there is no gap word.
REQ-042 rst asserted during DATA_A of a len=8 TLP → all outputs are 0 on the next cycle, and a fresh request completes normally.
